// File: rtl/irq_sync_ctrl.sv
// Interrupt front-end: synchronizes external lines, latches edge/level events as pending
// bits, masks them and drives a registered request vector; optional glitch filter under IRQ_FILTER_EN.
module irq_sync_ctrl #(
    parameter int                N_IRQ       = 8,
    parameter logic [31:0]       BASE_ADDR   = 32'hFFFF_FF00,
    parameter logic [N_IRQ-1:0]  EDGE_MASK   = {N_IRQ{1'b1}},
    parameter int                FILT_CYCLES = 4
) (
    input  logic             ph1,
    input  logic             reset_b,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             memwrite,
    input  logic [31:0]      dataadr,
    input  logic [31:0]      writedata,
    input  logic             memread,
    output logic [31:0]      readdata,
    output logic [N_IRQ-1:0] irq_out
);

    logic [N_IRQ-1:0] sync1_q, sync2_q, prev_q;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic [N_IRQ-1:0] irq_out_q;
    logic [31:0]      readdata_q, readdata_d;
    logic [1:0]       arm_cnt_q, arm_cnt_d;
    logic [N_IRQ-1:0] lvl, set, clr;
    logic             hit, wr, armed;
    logic [1:0]       offset;
    logic             unused_bits;

`ifdef IRQ_FILTER_EN
    localparam int               CW        = $clog2(FILT_CYCLES + 1);
    localparam logic [CW-1:0]    FILT_LAST = CW'(FILT_CYCLES - 1);
    logic [N_IRQ-1:0]          filt_q;
    logic [N_IRQ-1:0][CW-1:0]  cnt_q;

    // filt flips only after FILT_CYCLES consecutive disagreeing samples of sync2
    always_ff @(posedge ph1 or negedge reset_b) begin
        if (!reset_b) begin
            filt_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < N_IRQ; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == FILT_LAST) begin
                    cnt_q[i]  <= '0;
                    filt_q[i] <= ~filt_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign lvl = filt_q;
`else
    localparam int unused_filt_cycles = FILT_CYCLES;
    assign lvl = sync2_q;
`endif

    // Bus: memwrite/memread are single-cycle strobes sampled on posedge ph1 with
    // dataadr/writedata; readdata answers a sampled read on the following cycle, 0 otherwise.
    assign hit    = (dataadr[31:4] == BASE_ADDR[31:4]);
    assign offset = dataadr[3:2];
    assign wr     = memwrite & hit;
    assign armed  = (arm_cnt_q == 2'd3);
    assign unused_bits = ^{dataadr[1:0], writedata};

    always_comb begin
        clr        = '0;
        mask_d     = mask_q;
        set        = '0;
        readdata_d = '0;
        arm_cnt_d  = armed ? arm_cnt_q : arm_cnt_q + 2'd1;
        if (wr && offset == 2'd1) mask_d = writedata[N_IRQ-1:0];
        if (wr && offset == 2'd2) clr    = writedata[N_IRQ-1:0];
        if (armed) set = (EDGE_MASK & lvl & ~prev_q) | (~EDGE_MASK & lvl);
        // set wins over a same-cycle clear so no event is lost
        pending_d = set | (pending_q & ~clr);
        if (memread && hit) begin
            case (offset)
                2'd0:    readdata_d = 32'(pending_q);
                2'd1:    readdata_d = 32'(mask_q);
                2'd2:    readdata_d = '0;
                default: readdata_d = 32'(lvl);
            endcase
        end
    end

    always_ff @(posedge ph1 or negedge reset_b) begin
        if (!reset_b) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            irq_out_q  <= '0;
            readdata_q <= '0;
            arm_cnt_q  <= '0;
        end else begin
            sync1_q    <= irq_in;
            sync2_q    <= sync1_q;
            prev_q     <= lvl;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            irq_out_q  <= pending_q & mask_q;
            readdata_q <= readdata_d;
            arm_cnt_q  <= arm_cnt_d;
        end
    end

    assign irq_out  = irq_out_q;
    assign readdata = readdata_q;

endmodule
